// File: rtl/slave_controller.sv
// I2C slave link controller.
// Sequences a slave transaction from the decoded SCL edges and START/STOP
// pulses. It strobes the RX/TX shift registers, requests TX FIFO loads and
// selects what the slave drives onto SDA. Every output is a flop, so each
// response appears in the cycle after the pulse that triggers it.
module slave_controller (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic       address_match,
  input  logic       rw_mode,
  input  logic       sda_in,
  output logic       rx_enable,
  output logic       rx_data_ready,
  output logic       tx_enable,
  output logic       load_data,
  output logic [1:0] sda_mode,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    RX_BYTE,
    RX_ACKWAIT,
    ACK,
    TX_BYTE,
    M_ACK,
    M_ACKWAIT,
    IGNORE
  } state_t;

  // SDA drive encodings
  localparam logic [1:0] SDA_RELEASE = 2'b00;
  localparam logic [1:0] SDA_ACK     = 2'b01;
  localparam logic [1:0] SDA_TX      = 2'b11;

  state_t     state, state_next;
  logic [3:0] count, count_next;
  logic       first_byte, first_byte_next;

  logic       rx_enable_next;
  logic       rx_data_ready_next;
  logic       tx_enable_next;
  logic       load_data_next;
  logic [1:0] sda_mode_next;
  logic       busy_next;

  // Next state, counter and output values
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    state_next         = state;
    count_next         = count;
    first_byte_next    = first_byte;
    rx_enable_next     = 1'b0;
    rx_data_ready_next = 1'b0;
    tx_enable_next     = 1'b0;
    load_data_next     = 1'b0;

    if (stop_found) begin
      // STOP takes priority over everything, including a START in the same cycle.
      state_next      = IDLE;
      count_next      = 4'd0;
      first_byte_next = 1'b0;
    end else if (start_found) begin
      // A START or repeated START always begins a fresh address byte.
      state_next      = RX_BYTE;
      count_next      = 4'd0;
      first_byte_next = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        RX_BYTE: begin
          if (rising_edge_found) begin
            rx_enable_next = 1'b1;
            count_next     = count + 4'd1;
            if (count == 4'd7) begin
              state_next         = RX_ACKWAIT;
              rx_data_ready_next = !first_byte;
            end
          end
        end
        RX_ACKWAIT: begin
          if (falling_edge_found) begin
            if (first_byte && !address_match) begin
              state_next = IGNORE;
            end else begin
              state_next     = ACK;
              load_data_next = first_byte && rw_mode;
            end
          end
        end
        ACK: begin
          if (falling_edge_found) begin
            count_next = 4'd0;
            if (rw_mode) begin
              state_next = TX_BYTE;
            end else begin
              state_next      = RX_BYTE;
              first_byte_next = 1'b0;
            end
          end
        end
        TX_BYTE: begin
          // The first bit is already on the line when the byte is loaded, so
          // only the first seven falls shift; the eighth hands SDA to the master.
          if (falling_edge_found) begin
            count_next = count + 4'd1;
            if (count == 4'd7) begin
              state_next = M_ACK;
            end else begin
              tx_enable_next = 1'b1;
            end
          end
        end
        M_ACK: begin
          if (rising_edge_found) begin
            if (!sda_in) begin
              state_next     = M_ACKWAIT;
              load_data_next = 1'b1;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        M_ACKWAIT: begin
          if (falling_edge_found) begin
            state_next = TX_BYTE;
            count_next = 4'd0;
          end
        end
        IGNORE: ;
        default: state_next = IDLE;
      endcase
    end

    // SDA drive is fixed by the state being entered.
    unique case (state_next)
      ACK:     sda_mode_next = SDA_ACK;
      TX_BYTE: sda_mode_next = SDA_TX;
      default: sda_mode_next = SDA_RELEASE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: the reset branch clears outputs without waiting for a clock edge,
    // so SDA is released the moment n_rst falls.
    if (!n_rst) begin
      state         <= IDLE;
      count         <= 4'd0;
      first_byte    <= 1'b0;
      rx_enable     <= 1'b0;
      rx_data_ready <= 1'b0;
      tx_enable     <= 1'b0;
      load_data     <= 1'b0;
      sda_mode      <= SDA_RELEASE;
      busy          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state         <= state_next;
      count         <= count_next;
      first_byte    <= first_byte_next;
      rx_enable     <= rx_enable_next;
      rx_data_ready <= rx_data_ready_next;
      tx_enable     <= tx_enable_next;
      load_data     <= load_data_next;
      sda_mode      <= sda_mode_next;
      busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_slave_controller.sv
// Self-checking bench for slave_controller: a table of single-cycle vectors
// followed by hand-written write, NACKed-address, read, reset and
// repeated-start sequences.
module tb_slave_controller;

  logic       clk;
  logic       n_rst;
  logic       start_found;
  logic       stop_found;
  logic       rising_edge_found;
  logic       falling_edge_found;
  logic       address_match;
  logic       rw_mode;
  logic       sda_in;
  logic       rx_enable;
  logic       rx_data_ready;
  logic       tx_enable;
  logic       load_data;
  logic [1:0] sda_mode;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters
  int rx_cnt   = 0;
  int rdy_cnt  = 0;
  int tx_cnt   = 0;
  int load_cnt = 0;

  // Outputs seen right after the most recent rising-edge pulse
  logic last_rx_en;
  logic last_rdy;

  localparam int P_START = 0;
  localparam int P_STOP  = 1;
  localparam int P_RISE  = 2;
  localparam int P_FALL  = 3;

  typedef struct {
    logic       start;
    logic       stop;
    logic       rise;
    logic       fall;
    logic [6:0] exp;  // {rx_enable, rx_data_ready, tx_enable, load_data, sda_mode, busy}
  } vec_t;

  vec_t vecs[$];

  slave_controller dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .start_found       (start_found),
    .stop_found        (stop_found),
    .rising_edge_found (rising_edge_found),
    .falling_edge_found(falling_edge_found),
    .address_match     (address_match),
    .rw_mode           (rw_mode),
    .sda_in            (sda_in),
    .rx_enable         (rx_enable),
    .rx_data_ready     (rx_data_ready),
    .tx_enable         (tx_enable),
    .load_data         (load_data),
    .sda_mode          (sda_mode),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses shortly after each rising edge
  always @(posedge clk) begin
    #1;
    if (rx_enable)     rx_cnt++;
    if (rx_data_ready) rdy_cnt++;
    if (tx_enable)     tx_cnt++;
    if (load_data)     load_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic p, input logic r, input logic f,
                              input logic [6:0] e);
    vec_t v;
    v.start = s;
    v.stop  = p;
    v.rise  = r;
    v.fall  = f;
    v.exp   = e;
    return v;
  endfunction

  // One-cycle input pulse, then sample outputs at the following falling edge
  task automatic pulse(input int kind);
    @(negedge clk);
    case (kind)
      P_START: start_found        = 1'b1;
      P_STOP:  stop_found         = 1'b1;
      P_RISE:  rising_edge_found  = 1'b1;
      default: falling_edge_found = 1'b1;
    endcase
    @(negedge clk);
    start_found        = 1'b0;
    stop_found         = 1'b0;
    rising_edge_found  = 1'b0;
    falling_edge_found = 1'b0;
    if (kind == P_RISE) begin
      last_rx_en = rx_enable;
      last_rdy   = rx_data_ready;
    end
  endtask

  // n SCL clocks, MSB first on sda_in
  task automatic send_bits(input logic [7:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      sda_in = data[7-i];
      pulse(P_RISE);
      pulse(P_FALL);
    end
  endtask

  int base_rx, base_rdy, base_tx, base_load;

  task automatic snap();
    base_rx   = rx_cnt;
    base_rdy  = rdy_cnt;
    base_tx   = tx_cnt;
    base_load = load_cnt;
  endtask

  initial begin
    n_rst              = 1'b0;
    start_found        = 1'b0;
    stop_found         = 1'b0;
    rising_edge_found  = 1'b0;
    falling_edge_found = 1'b0;
    address_match      = 1'b1;
    rw_mode            = 1'b0;
    sda_in             = 1'b1;

    // Reset state, before any clock edge
    #3;
    check("reset_sda_mode", sda_mode, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_pulses", {rx_enable, rx_data_ready, tx_enable, load_data}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // ---------------- table-driven vectors ----------------
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000_00_0));  // idle
    vecs.push_back(mk(0, 0, 1, 0, 7'b0000_00_0));  // rise ignored in IDLE
    vecs.push_back(mk(1, 0, 0, 0, 7'b0000_00_1));  // start -> RX_BYTE
    vecs.push_back(mk(0, 0, 1, 0, 7'b1000_00_1));  // rx_enable pulse
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000_00_1));  // pulse lasts one cycle
    vecs.push_back(mk(0, 0, 0, 1, 7'b0000_00_1));  // fall ignored in RX_BYTE
    vecs.push_back(mk(1, 1, 0, 0, 7'b0000_00_0));  // start+stop: stop wins
    vecs.push_back(mk(1, 0, 0, 0, 7'b0000_00_1));  // start again
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 1, 0, 7'b1000_00_1)); // 8 address bits, no rx_data_ready
    vecs.push_back(mk(0, 0, 0, 1, 7'b0000_01_1));  // fall -> ACK
    vecs.push_back(mk(0, 0, 1, 0, 7'b0000_01_1));  // ACK held through 9th clock
    vecs.push_back(mk(0, 0, 0, 1, 7'b0000_00_1));  // write -> RX_BYTE, released
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000_00_1));
    vecs.push_back(mk(0, 1, 0, 0, 7'b0000_00_0));  // stop -> IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      start_found        = vecs[i].start;
      stop_found         = vecs[i].stop;
      rising_edge_found  = vecs[i].rise;
      falling_edge_found = vecs[i].fall;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {rx_enable, rx_data_ready, tx_enable, load_data, sda_mode, busy}, vecs[i].exp);
    end
    start_found        = 1'b0;
    stop_found         = 1'b0;
    rising_edge_found  = 1'b0;
    falling_edge_found = 1'b0;

    // ---------------- write 0xF0 then 0xA5 ----------------
    snap();
    address_match = 1'b1;
    rw_mode       = 1'b0;
    pulse(P_START);
    send_bits(8'hF0, 8);
    check("wr_addr_rx_pulses", rx_cnt - base_rx, 8);
    check("wr_addr_no_ready", rdy_cnt - base_rdy, 0);
    check("wr_addr_ack", sda_mode, 2'b01);
    pulse(P_RISE);
    check("wr_addr_ack_hold", sda_mode, 2'b01);
    pulse(P_FALL);
    check("wr_addr_release", {sda_mode, busy}, 3'b00_1);
    send_bits(8'hA5, 7);
    check("wr_data_no_early_ready", rdy_cnt - base_rdy, 0);
    send_bits(8'h01, 1);
    check("wr_data_ready_with_8th", {last_rx_en, last_rdy}, 2'b11);
    check("wr_data_rx_pulses", rx_cnt - base_rx, 16);
    check("wr_data_ready_count", rdy_cnt - base_rdy, 1);
    check("wr_data_ack", sda_mode, 2'b01);
    pulse(P_RISE);
    pulse(P_FALL);
    check("wr_data_release", sda_mode, 2'b00);
    pulse(P_STOP);
    check("wr_stop_idle", {sda_mode, busy}, 3'b00_0);

    // ---------------- address 0xD0 not matched ----------------
    snap();
    address_match = 1'b0;
    pulse(P_START);
    send_bits(8'hD0, 8);
    check("nm_no_ack", {sda_mode, busy}, 3'b00_1);
    pulse(P_RISE);
    check("nm_9th_rise", sda_mode, 2'b00);
    pulse(P_FALL);
    check("nm_9th_fall", {sda_mode, busy}, 3'b00_1);
    send_bits(8'h55, 3);
    check("nm_ignored_bits", rx_cnt - base_rx, 8);
    address_match = 1'b1;
    pulse(P_START);
    send_bits(8'hF0, 8);
    check("nm_restart_ack", sda_mode, 2'b01);
    pulse(P_STOP);

    // ---------------- read with 0xF1 ----------------
    snap();
    address_match = 1'b1;
    rw_mode       = 1'b1;
    pulse(P_START);
    send_bits(8'hF1, 8);
    check("rd_addr_load", load_cnt - base_load, 1);
    check("rd_addr_ack", sda_mode, 2'b01);
    pulse(P_RISE);
    pulse(P_FALL);
    check("rd_tx_drive", sda_mode, 2'b11);
    send_bits(8'h00, 7);
    check("rd_tx_7_pulses", tx_cnt - base_tx, 7);
    check("rd_tx_still_drive", sda_mode, 2'b11);
    send_bits(8'h00, 1);
    check("rd_tx_no_8th_pulse", tx_cnt - base_tx, 7);
    check("rd_tx_release", sda_mode, 2'b00);
    sda_in = 1'b0;
    pulse(P_RISE);
    check("rd_mack_load", load_cnt - base_load, 2);
    pulse(P_FALL);
    check("rd_byte2_drive", sda_mode, 2'b11);
    send_bits(8'h00, 8);
    check("rd_byte2_pulses", tx_cnt - base_tx, 14);
    check("rd_byte2_release", sda_mode, 2'b00);
    sda_in = 1'b1;
    pulse(P_RISE);
    pulse(P_FALL);
    check("rd_nack_ignore", {sda_mode, busy}, 3'b00_1);
    send_bits(8'h00, 8);
    check("rd_nack_no_tx", tx_cnt - base_tx, 14);
    check("rd_nack_no_load", load_cnt - base_load, 2);

    // ---------------- async reset during TX_BYTE ----------------
    pulse(P_START);
    send_bits(8'hF1, 8);
    pulse(P_RISE);
    pulse(P_FALL);
    check("rst_pre_drive", {sda_mode, busy}, 3'b11_1);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("rst_async_release", {sda_mode, busy}, 3'b00_0);
    @(negedge clk);
    n_rst = 1'b1;
    snap();
    rw_mode = 1'b0;
    send_bits(8'hF0, 8);
    pulse(P_RISE);
    pulse(P_FALL);
    check("rst_resume_idle", {sda_mode, busy}, 3'b00_0);
    check("rst_bus_ignored", (rx_cnt - base_rx) + (tx_cnt - base_tx), 0);

    // ---------------- repeated start after 4 data bits ----------------
    snap();
    address_match = 1'b1;
    rw_mode       = 1'b0;
    pulse(P_START);
    send_bits(8'hF0, 8);
    pulse(P_RISE);
    pulse(P_FALL);
    send_bits(8'hA0, 4);
    pulse(P_START);
    check("rs_busy", {sda_mode, busy}, 3'b00_1);
    send_bits(8'hF0, 7);
    check("rs_counter_cleared", sda_mode, 2'b00);
    send_bits(8'h00, 1);
    check("rs_first_byte_no_ready", rdy_cnt - base_rdy, 0);
    check("rs_addr_ack", sda_mode, 2'b01);

    // ---------------- start and stop together in RX_BYTE ----------------
    pulse(P_RISE);
    pulse(P_FALL);
    send_bits(8'h0F, 2);
    @(negedge clk);
    start_found = 1'b1;
    stop_found  = 1'b1;
    @(negedge clk);
    start_found = 1'b0;
    stop_found  = 1'b0;
    check("ss_idle", {sda_mode, busy}, 3'b00_0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_controller.md
SLAVE_CONTROLLER -- requirements
Module: slave_controller

Interface
REQ-001: The block SHALL be a single-clock design with an asynchronous, active-low reset.
REQ-002: Port: clk  in  1  system clock; all state changes occur on its rising edge.
REQ-003: Port: n_rst  in  1  asynchronous active-low reset.
REQ-004: Port: start_found  in  1  one-cycle pulse from decode; I2C start or repeated start seen.
REQ-005: Port: stop_found  in  1  one-cycle pulse from decode; I2C stop seen.
REQ-006: Port: rising_edge_found  in  1  one-cycle pulse on each synchronized SCL rise.
REQ-007: Port: falling_edge_found  in  1  one-cycle pulse on each synchronized SCL fall.
REQ-008: Port: address_match  in  1  decode result; the received byte's upper 7 bits equal 7'b1111000.
REQ-009: Port: rw_mode  in  1  decode result; bit 0 of the received first byte (1 = master read).
REQ-010: Port: sda_in  in  1  synchronized SDA level.
REQ-011: Port: rx_enable  out  1  shift-in strobe to the RX shift register.
REQ-012: Port: rx_data_ready  out  1  one-cycle pulse; a write-data byte is complete.
REQ-013: Port: tx_enable  out  1  shift-out strobe to the TX shift register.
REQ-014: Port: load_data  out  1  one-cycle pulse; load the TX shift register from the TX FIFO.
REQ-015: Port: sda_mode  out  2  SDA drive select: 00 = release, 01 = drive 0 (ACK), 10 = drive 1, 11 = drive TX bit.
REQ-016: Port: busy  out  1  high in every state other than IDLE.

Function
REQ-017: States SHALL be IDLE, RX_BYTE, RX_ACKWAIT, ACK, TX_BYTE, M_ACK, M_ACKWAIT and IGNORE.
REQ-018: A 4-bit bit counter (0..8) SHALL count SCL edges within a byte, plus one first_byte flag.
REQ-019: All outputs SHALL be registered and SHALL assert in the cycle after the triggering input pulse.
REQ-020: IDLE: on start_found -> RX_BYTE with counter = 0 and first_byte = 1.
REQ-021: RX_BYTE: rx_enable SHALL pulse for exactly one cycle per rising_edge_found, with counter += 1.
REQ-022: RX_BYTE: on the 8th rising edge -> RX_ACKWAIT; if first_byte = 0, rx_data_ready SHALL pulse together with the 8th rx_enable.
REQ-023: RX_ACKWAIT, on falling_edge_found when first_byte = 1 and address_match = 0 -> IGNORE with sda_mode = 00.
REQ-024: RX_ACKWAIT, on falling_edge_found otherwise -> ACK with sda_mode = 01.
REQ-025: RX_ACKWAIT: if first_byte = 1 and rw_mode = 1, load_data SHALL pulse at the same transition as REQ-024.
REQ-026: ACK: sda_mode SHALL hold 01 until the next falling_edge_found, then:
  - rw_mode = 0 -> RX_BYTE, counter = 0, first_byte = 0, sda_mode = 00;
  - rw_mode = 1 -> TX_BYTE, counter = 0, sda_mode = 11.
REQ-027: TX_BYTE: sda_mode = 11; each falling_edge_found SHALL increment the counter.
REQ-028: TX_BYTE: falling edges 1..7 SHALL each pulse tx_enable for one cycle.
REQ-029: TX_BYTE: the 8th falling edge -> M_ACK with sda_mode = 00 and no tx_enable.
REQ-030: M_ACK: on rising_edge_found, sample sda_in:
  - 0 -> M_ACKWAIT with a load_data pulse;
  - 1 -> IGNORE.
REQ-031: M_ACKWAIT: on falling_edge_found -> TX_BYTE, counter = 0, sda_mode = 11.
REQ-032: IGNORE: outputs idle, sda_mode = 00; leave only on start_found or stop_found.
REQ-033: stop_found in any state SHALL force IDLE next cycle with all outputs 0.
REQ-034: start_found in any non-IDLE state SHALL force RX_BYTE next cycle with counter = 0, first_byte = 1, all outputs 0.
REQ-035: If start_found and stop_found are both high in one cycle, stop_found SHALL win.
REQ-036: Edge pulses arriving in a state that does not consume them SHALL be ignored.
REQ-037: The counter SHALL never exceed 8; it is cleared on every byte start.

Reset
REQ-038: While n_rst = 0: state = IDLE, counter = 0, first_byte = 0, and every output = 0 (sda_mode = 00), regardless of clk.
REQ-039: Release of n_rst mid-transfer SHALL resume in IDLE; the bus is ignored until the next start_found.

Verification
REQ-040: Reset during TX_BYTE with sda_mode = 11 -> sda_mode = 00 and busy = 0 immediately, without a clock edge.
REQ-041: Write of 0xF0 then 0xA5, sequence:
  - 8 rx_enable pulses, ACK (sda_mode = 01) over the 9th clock;
  - 8 more rx_enable pulses, one rx_data_ready, ACK;
  - stop -> IDLE.
REQ-042: Address byte 0xD0 (address_match = 0) -> no ACK, state IGNORE, sda_mode = 00 through the 9th clock; later start_found -> RX_BYTE.
REQ-043: Read with 0xF1, sequence:
  - load_data at the address ACK, then sda_mode = 11;
  - exactly 7 tx_enable pulses, then sda_mode = 00 at the 8th fall;
  - master ACK (sda_in = 0) -> load_data and a second byte;
  - master NACK (sda_in = 1) -> IGNORE.
REQ-044: Repeated start after the 4th data bit -> counter 0, first_byte = 1, no rx_data_ready pulse.
REQ-045: start_found and stop_found in the same cycle during RX_BYTE -> IDLE, busy = 0.
